// File: rtl/ex_muldiv.sv
// Iterative EX-stage multiply/divide unit: MULT/MULTU/DIV/DIVU over 32 cycles,
// holding the 64-bit HI/LO result and requesting a pipeline hold while it works.
module ex_muldiv #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [1:0]            op_i,
    input  logic [DATA_WIDTH-1:0] src_a_i,
    input  logic [DATA_WIDTH-1:0] src_b_i,
    input  logic                  flush_i,
    output logic                  stall_req_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  div_by_zero_o,
    output logic [DATA_WIDTH-1:0] hi_o,
    output logic [DATA_WIDTH-1:0] lo_o
);

    localparam int unsigned DW = DATA_WIDTH;
    localparam int unsigned AW = 2 * DATA_WIDTH;
    localparam int unsigned CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_FIN  = 2'b11
    } state_e;

    state_e         state_q;
    logic [CW-1:0]  cnt_q;
    logic [AW-1:0]  acc_q;
    logic [AW-1:0]  acc_d;
    logic [DW-1:0]  opb_q;
    logic           sign_q;
    logic           sign_rem_q;
    logic           busy_q;
    logic           done_q;
    logic           dbz_q;
    logic [DW-1:0]  hi_q;
    logic [DW-1:0]  lo_q;

    // Issue-cycle decode: op[0] selects signed, op[1] selects divide.
    logic           op_signed;
    logic           op_div;
    logic [DW-1:0]  mag_a;
    logic [DW-1:0]  mag_b;

    assign op_signed = op_i[0];
    assign op_div    = op_i[1];
    assign mag_a     = (op_signed && src_a_i[DW-1]) ? -src_a_i : src_a_i;
    assign mag_b     = (op_signed && src_b_i[DW-1]) ? -src_b_i : src_b_i;

    // One iteration step: shift-add for multiply, restoring step for divide.
    // The accumulator holds {partial product, multiplier} or {remainder, quotient}.
    logic [DW:0] mul_sum;
    logic [DW:0] div_shift;
    logic [DW:0] div_trial;

    always_comb begin
        mul_sum   = {1'b0, acc_q[AW-1:DW]} + (acc_q[0] ? {1'b0, opb_q} : {(DW+1){1'b0}});
        div_shift = acc_q[AW-1:DW-1];
        div_trial = div_shift - {1'b0, opb_q};
        acc_d     = acc_q;
        if (state_q == ST_MUL) begin
            acc_d = {mul_sum, acc_q[DW-1:1]};
        end else if (!div_trial[DW]) begin
            acc_d = {div_trial[DW-1:0], acc_q[DW-2:0], 1'b1};
        end else begin
            acc_d = {div_shift[DW-1:0], acc_q[DW-2:0], 1'b0};
        end
    end

    // Sign correction applied as the final value is written back.
    logic [AW-1:0] mul_res;
    logic [DW-1:0] quo_res;
    logic [DW-1:0] rem_res;

    assign mul_res = sign_q     ? -acc_d           : acc_d;
    assign quo_res = sign_q     ? -acc_d[DW-1:0]   : acc_d[DW-1:0];
    assign rem_res = sign_rem_q ? -acc_d[AW-1:DW]  : acc_d[AW-1:DW];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            opb_q      <= '0;
            sign_q     <= 1'b0;
            sign_rem_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dbz_q      <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            if (flush_i) begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start_i) begin
                            cnt_q      <= '0;
                            opb_q      <= op_div ? mag_b : mag_a;
                            sign_q     <= op_signed & (src_a_i[DW-1] ^ src_b_i[DW-1]);
                            sign_rem_q <= op_signed & src_a_i[DW-1];
                            if (op_div && (src_b_i == '0)) begin
                                state_q <= ST_FIN;
                                done_q  <= 1'b1;
                                dbz_q   <= 1'b1;
                            end else if (op_div) begin
                                state_q <= ST_DIV;
                                busy_q  <= 1'b1;
                                acc_q   <= {{DW{1'b0}}, mag_a};
                            end else begin
                                state_q <= ST_MUL;
                                busy_q  <= 1'b1;
                                acc_q   <= {{DW{1'b0}}, mag_b};
                            end
                        end
                    end
                    ST_MUL, ST_DIV: begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q + CW'(1);
                        if (cnt_q == LAST_ITER) begin
                            state_q <= ST_FIN;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            if (state_q == ST_MUL) begin
                                hi_q <= mul_res[AW-1:DW];
                                lo_q <= mul_res[DW-1:0];
                            end else begin
                                hi_q <= rem_res;
                                lo_q <= quo_res;
                            end
                        end
                    end
                    ST_FIN: begin
                        state_q <= ST_IDLE;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Hold request rises combinationally in the issue cycle so the ID/EX stage freezes at once.
    assign stall_req_o   = rst_ni & (((state_q == ST_IDLE) & start_i & ~flush_i) | busy_q);
    assign busy_o        = rst_ni & busy_q;
    assign done_o        = done_q;
    assign div_by_zero_o = dbz_q;
    assign hi_o          = hi_q;
    assign lo_o          = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: a schedule-level reference model checked every cycle,
// plus hand-computed result and latency expectations.
module tb_ex_muldiv;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        stall_req;
    logic        busy;
    logic        done;
    logic        dbz;
    logic [31:0] hi;
    logic [31:0] lo;

    ex_muldiv #(.DATA_WIDTH(32)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .op_i         (op),
        .src_a_i      (src_a),
        .src_b_i      (src_b),
        .flush_i      (flush),
        .stall_req_o  (stall_req),
        .busy_o       (busy),
        .done_o       (done),
        .div_by_zero_o(dbz),
        .hi_o         (hi),
        .lo_o         (lo)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Architectural result from plain integer arithmetic.
    function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'b00:   return {32'b0, a} * {32'b0, b};
            2'b01:   return 64'(sa * sb);
            2'b10:   return {a % b, a / b};
            default: begin
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
        endcase
    endfunction

    // Schedule model: an op issued in cycle t finishes in t+33 (t+1 for divide by zero).
    bit          m_active = 1'b0;
    bit          m_dbz    = 1'b0;
    int          m_t      = 0;
    int          m_td     = 0;
    logic [63:0] m_res    = '0;
    logic [31:0] m_hi     = '0;
    logic [31:0] m_lo     = '0;

    always @(posedge clk) begin
        bit idle;
        idle = !m_active || (cyc > m_td);
        if (!rst_n) begin
            m_active = 1'b0;
            m_hi     = '0;
            m_lo     = '0;
        end else begin
            if (m_active && !m_dbz && (cyc == m_td - 1) && !flush) begin
                m_hi = m_res[63:32];
                m_lo = m_res[31:0];
            end
            if (m_active && flush && (cyc < m_td)) m_active = 1'b0;
            if (idle && start && !flush) begin
                m_active = 1'b1;
                m_t      = cyc;
                m_dbz    = op[1] && (src_b == 32'd0);
                m_td     = cyc + (m_dbz ? 1 : 33);
                if (!m_dbz) m_res = ref_result(op, src_a, src_b);
            end
        end
        cyc++;
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            bit e_busy;
            bit e_done;
            bit e_idle;
            bit e_stall;
            e_idle  = !m_active || (cyc > m_td);
            e_busy  = rst_n && m_active && !m_dbz && (cyc >= m_t + 1) && (cyc <= m_t + 32);
            e_done  = m_active && (cyc == m_td);
            e_stall = rst_n && ((e_idle && start && !flush) || e_busy);
            check("cyc_stall_req", 64'(stall_req), 64'(e_stall));
            check("cyc_busy", 64'(busy), 64'(e_busy));
            check("cyc_done", 64'(done), 64'(e_done));
            check("cyc_div_by_zero", 64'(dbz), 64'(e_done && m_dbz));
            check("cyc_hi", 64'(hi), 64'(m_hi));
            check("cyc_lo", 64'(lo), 64'(m_lo));
        end
    end

    // Issue one op, wait (bounded) for done, and pin latency and result to literals.
    task automatic do_op(input string name, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input int lat, input logic [31:0] x_hi,
                         input logic [31:0] x_lo);
        int t;
        int seen;
        @(posedge clk); #1;
        start = 1'b1; op = o; src_a = a; src_b = b;
        t = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        seen = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (done) begin
                seen = cyc;
                break;
            end
        end
        check({name, "_done_cycle"}, 64'(seen - t), 64'(lat));
        check({name, "_hi"}, 64'(hi), 64'(x_hi));
        check({name, "_lo"}, 64'(lo), 64'(x_lo));
        check({name, "_dbz"}, 64'(dbz), 64'(lat == 1));
    endtask

    typedef struct {
        logic [1:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] x_hi;
        logic [31:0] x_lo;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int dcount;
        vecs[0] = '{2'b11, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
        vecs[1] = '{2'b11, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd3};
        vecs[2] = '{2'b10, 32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF};
        vecs[3] = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'd0};

        rst_n = 1'b0; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0; flush = 1'b0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        start  = 1'b1;
        @(negedge clk);
        check("reset_stall_gated", 64'(stall_req), 64'd0);
        check("reset_hi_lo", {hi, lo}, 64'd0);
        @(posedge clk); #1;
        start = 1'b0;
        rst_n = 1'b1;

        do_op("multu_max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'hFFFFFFFE, 32'h00000001);
        @(negedge clk);
        check("multu_done_drops", 64'(done), 64'd0);
        do_op("mult_neg", 2'b01, 32'hFFFFFFFD, 32'h00000007, 33, 32'hFFFFFFFF, 32'hFFFFFFEB);
        do_op("div_neg", 2'b11, 32'hFFFFFFF9, 32'h00000002, 33, 32'hFFFFFFFF, 32'hFFFFFFFD);
        do_op("div_ovf", 2'b11, 32'h80000000, 32'hFFFFFFFF, 33, 32'h00000000, 32'h80000000);
        do_op("divu_100_7", 2'b10, 32'd100, 32'd7, 33, 32'd2, 32'd14);
        do_op("divu_zero", 2'b10, 32'd100, 32'd0, 1, 32'd2, 32'd14);

        // Flush a DIVU mid-flight, then issue a MULTU right after.
        @(posedge clk); #1;
        start = 1'b1; op = 2'b10; src_a = 32'd1000; src_b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_busy_clear", 64'(busy), 64'd0);
        check("flush_hi_lo_kept", {hi, lo}, {32'd2, 32'd14});
        do_op("multu_6_7", 2'b00, 32'd6, 32'd7, 33, 32'd0, 32'd42);

        // Start and flush together: the op never begins.
        @(posedge clk); #1;
        start = 1'b1; flush = 1'b1; op = 2'b00; src_a = 32'd3; src_b = 32'd3;
        @(negedge clk);
        check("flush_at_issue_stall", 64'(stall_req), 64'd0);
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("flush_at_issue_busy", 64'(busy), 64'd0);

        foreach (vecs[i]) do_op($sformatf("vec%0d", i), vecs[i].o, vecs[i].a, vecs[i].b, 33,
                                vecs[i].x_hi, vecs[i].x_lo);

        // Reset in the middle of a MULT.
        @(posedge clk); #1;
        start = 1'b1; op = 2'b01; src_a = 32'h12345678; src_b = 32'h9ABCDEF0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_mid_hi_lo", {hi, lo}, 64'd0);
        check("rst_mid_flags", {61'd0, busy, stall_req, done}, 64'd0);
        dcount = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("rst_mid_no_done", 64'(dcount), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
